// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller: phase states, per-lamp
// encoding and the helpers that map a phase onto one direction's lamps.
package traffic_pkg;

  typedef enum logic [2:0] {
    GREEN     = 3'd0,
    YELLOW    = 3'd1,
    ALLRED    = 3'd2,
    NIGHT_ON  = 3'd3,
    NIGHT_OFF = 3'd4
  } state_t;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_RED = '{r: 1'b1, y: 1'b0, g: 1'b0};
  localparam lamp_t LAMP_YEL = '{r: 1'b0, y: 1'b1, g: 1'b0};
  localparam lamp_t LAMP_GRN = '{r: 1'b0, y: 1'b0, g: 1'b1};
  localparam lamp_t LAMP_OFF = '{r: 1'b0, y: 1'b0, g: 1'b0};

  function automatic int dir_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic lamp_t lamp_of(input state_t s, input logic served);
    lamp_t l;
    case (s)
      GREEN:     l = served ? LAMP_GRN : LAMP_RED;
      YELLOW:    l = served ? LAMP_YEL : LAMP_RED;
      ALLRED:    l = LAMP_RED;
      NIGHT_ON:  l = LAMP_YEL;
      NIGHT_OFF: l = LAMP_OFF;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_if.sv
// Controller-facing signal bundle: timing/request inputs and lamp drives.
interface traffic_if #(
  parameter int N_DIR = 2
);
  import traffic_pkg::*;

  localparam int DIR_W = dir_width(N_DIR);

  logic             tick;
  logic             night;
  logic [N_DIR-1:0] ped_req;
  logic [N_DIR-1:0] r;
  logic [N_DIR-1:0] y;
  logic [N_DIR-1:0] g;
  logic [N_DIR-1:0] walk;
  logic [DIR_W-1:0] dir;

  modport master (output tick, night, ped_req, input r, y, g, walk, dir);
  modport slave  (input tick, night, ped_req, output r, y, g, walk, dir);

endinterface

// File: rtl/traffic_ctrl_chk.sv
// Elaboration-time parameter checks for traffic_ctrl.
module traffic_ctrl_chk #(
  parameter int N_DIR    = 2,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int PED_EXT  = 3,
  parameter int BLINK_T  = 2
) ();

  if (N_DIR < 2 || N_DIR > 8) begin : g_bad_ndir
    $error("traffic_ctrl: N_DIR must be 2..8");
  end
  if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || BLINK_T < 1) begin : g_bad_dur
    $error("traffic_ctrl: every phase duration must be at least 1");
  end
  if (PED_EXT < 0 || CNT_W > 30 || (GREEN_T + PED_EXT) >= (1 << CNT_W)) begin : g_bad_width
    $error("traffic_ctrl: GREEN_T+PED_EXT does not fit the phase timer");
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Tick-enabled phase counter; done fires on the terminal tick of a phase
// whose length is supplied at run time.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);

  logic [CNT_W-1:0] t_r;

  // tick counter, cleared at the end of every phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_r <= '0;
    end else if (clr) begin
      t_r <= '0;
    end else if (tick) begin
      t_r <= t_r + CNT_W'(1);
    end
  end

  assign done = tick && (t_r == (dur - CNT_W'(1)));

endmodule

// File: rtl/traffic_ctrl.sv
// N-direction round-robin traffic-light controller with pedestrian walk
// extension and all-yellow night flashing.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int PED_EXT  = 3,
  parameter int BLINK_T  = 2
) (
  input  logic     clk,
  input  logic     rst,
  traffic_if.slave bus
);

  localparam int DIR_W = dir_width(N_DIR);

  state_t           state_r, nx_state_s;
  logic [DIR_W-1:0] dir_r, nx_dir_s;
  logic             grant_r, nx_grant_s;
  logic [N_DIR-1:0] ped_pend_r, nx_pend_s;
  logic [N_DIR-1:0] r_r, y_r, g_r, walk_r;
  logic [N_DIR-1:0] nx_r_s, nx_y_s, nx_g_s, nx_walk_s;
  logic [CNT_W-1:0] dur_s;
  logic             done_s;
  logic             enter_green_s;

  traffic_ctrl_chk #(
    .N_DIR(N_DIR), .CNT_W(CNT_W), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .PED_EXT(PED_EXT), .BLINK_T(BLINK_T)
  ) u_chk ();

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (bus.tick),
    .clr  (done_s),
    .dur  (dur_s),
    .done (done_s)
  );

  // length of the current phase
  always_comb begin
    dur_s = CNT_W'(GREEN_T);
    case (state_r)
      GREEN:     dur_s = grant_r ? CNT_W'(GREEN_T + PED_EXT) : CNT_W'(GREEN_T);
      YELLOW:    dur_s = CNT_W'(YELLOW_T);
      ALLRED:    dur_s = CNT_W'(ALLRED_T);
      NIGHT_ON:  dur_s = CNT_W'(BLINK_T);
      NIGHT_OFF: dur_s = CNT_W'(BLINK_T);
      default:   dur_s = CNT_W'(GREEN_T);
    endcase
  end

  // phase sequencing, direction rotation and pedestrian latch
  always_comb begin
    nx_state_s    = state_r;
    nx_dir_s      = dir_r;
    nx_grant_s    = grant_r;
    nx_pend_s     = ped_pend_r | bus.ped_req;
    enter_green_s = 1'b0;
    if (done_s) begin
      case (state_r)
        GREEN: nx_state_s = YELLOW;
        YELLOW: begin
          nx_state_s = ALLRED;
          nx_dir_s   = (dir_r == DIR_W'(N_DIR - 1)) ? '0 : dir_r + DIR_W'(1);
        end
        ALLRED: begin
          if (bus.night) begin
            nx_state_s = NIGHT_ON;
          end else begin
            nx_state_s    = GREEN;
            enter_green_s = 1'b1;
          end
        end
        NIGHT_ON:  nx_state_s = bus.night ? NIGHT_OFF : ALLRED;
        NIGHT_OFF: nx_state_s = bus.night ? NIGHT_ON : ALLRED;
        default:   nx_state_s = GREEN;
      endcase
    end else begin
      nx_state_s = state_r;
    end
    // a request on the entry edge is consumed by this green, not left pending
    if (enter_green_s) begin
      nx_grant_s       = nx_pend_s[dir_r];
      nx_pend_s[dir_r] = 1'b0;
    end else begin
      nx_grant_s = grant_r;
    end
  end

  // lamp pattern for the state being entered
  always_comb begin
    lamp_t lamp_v;
    logic  served_v;
    nx_r_s    = '0;
    nx_y_s    = '0;
    nx_g_s    = '0;
    nx_walk_s = '0;
    lamp_v    = LAMP_RED;
    served_v  = 1'b0;
    for (int d = 0; d < N_DIR; d++) begin
      served_v     = (nx_dir_s == DIR_W'(d));
      lamp_v       = lamp_of(nx_state_s, served_v);
      nx_r_s[d]    = lamp_v.r;
      nx_y_s[d]    = lamp_v.y;
      nx_g_s[d]    = lamp_v.g;
      nx_walk_s[d] = (nx_state_s == GREEN) && served_v && nx_grant_s;
    end
  end

  // state, latch and registered lamp outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= GREEN;
      dir_r      <= '0;
      grant_r    <= 1'b0;
      ped_pend_r <= '0;
      g_r        <= N_DIR'(1);
      r_r        <= ~N_DIR'(1);
      y_r        <= '0;
      walk_r     <= '0;
    end else begin
      state_r    <= nx_state_s;
      dir_r      <= nx_dir_s;
      grant_r    <= nx_grant_s;
      ped_pend_r <= nx_pend_s;
      g_r        <= nx_g_s;
      r_r        <= nx_r_s;
      y_r        <= nx_y_s;
      walk_r     <= nx_walk_s;
    end
  end

  assign bus.r    = r_r;
  assign bus.y    = y_r;
  assign bus.g    = g_r;
  assign bus.walk = walk_r;
  assign bus.dir  = dir_r;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed self-checking bench for traffic_ctrl (2 directions, default timing).
module tb_traffic_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  traffic_if #(.N_DIR(2)) bus ();

  traffic_ctrl #(
    .N_DIR(2), .CNT_W(8), .GREEN_T(5), .YELLOW_T(2),
    .ALLRED_T(1), .PED_EXT(3), .BLINK_T(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {r[1:0], y[1:0], g[1:0], walk[1:0], dir}
  localparam logic [8:0] G0   = 9'b10_00_01_00_0;
  localparam logic [8:0] Y0   = 9'b10_01_00_00_0;
  localparam logic [8:0] AR1  = 9'b11_00_00_00_1;
  localparam logic [8:0] G1   = 9'b01_00_10_00_1;
  localparam logic [8:0] G1W  = 9'b01_00_10_10_1;
  localparam logic [8:0] Y1   = 9'b01_10_00_00_1;
  localparam logic [8:0] AR0  = 9'b11_00_00_00_0;
  localparam logic [8:0] NON1 = 9'b00_11_00_00_1;
  localparam logic [8:0] NOF1 = 9'b00_00_00_00_1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {bus.r, bus.y, bus.g, bus.walk, bus.dir};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // check the current cycle, then advance one clock; repeat n times
  task automatic run(input string tag, input int n, input logic [8:0] exp);
    for (int k = 0; k < n; k++) begin
      check(tag, exp);
      step();
    end
  endtask

  // same, but with tick asserted only on every 4th cycle; n counts ticks
  task automatic run4(input string tag, input int n, input logic [8:0] exp);
    for (int k = 0; k < n; k++) begin
      bus.tick = 1'b0;
      for (int c = 0; c < 3; c++) begin
        check(tag, exp);
        step();
      end
      bus.tick = 1'b1;
      check(tag, exp);
      step();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.tick    = 1'b1;
    bus.night   = 1'b0;
    bus.ped_req = 2'b00;
    #2;
    check("reset", G0);
    step();
    rst = 1'b0;

    // basic round-robin, 16-cycle period
    run("s1_g0", 5, G0);
    run("s1_y0", 2, Y0);
    run("s1_ar1", 1, AR1);
    run("s1_g1", 5, G1);
    run("s1_y1", 2, Y1);
    run("s1_ar0", 1, AR0);

    // pedestrian request for dir1 raised during dir0 green
    bus.ped_req = 2'b10;
    run("s2_g0", 1, G0);
    bus.ped_req = 2'b00;
    run("s2_g0", 4, G0);
    run("s2_y0", 2, Y0);
    run("s2_ar1", 1, AR1);
    run("s2_g1walk", 8, G1W);
    run("s2_y1", 2, Y1);
    run("s2_ar0", 1, AR0);
    run("s2_g0b", 5, G0);
    run("s2_y0b", 2, Y0);
    run("s2_ar1b", 1, AR1);
    run("s2_g1nowalk", 5, G1);
    run("s2_y1b", 2, Y1);
    run("s2_ar0b", 1, AR0);

    // tick every 4th cycle stretches every phase by 4
    run4("s3_g0", 5, G0);
    run4("s3_y0", 2, Y0);
    run4("s3_ar1", 1, AR1);
    run4("s3_g1", 5, G1);
    run("s3_y1", 2, Y1);
    run("s3_ar0", 1, AR0);

    // night raised mid-green: cycle completes, then flashing
    run("s4_g0", 2, G0);
    bus.night = 1'b1;
    run("s4_g0", 3, G0);
    run("s4_y0", 2, Y0);
    run("s4_ar1", 1, AR1);
    run("s4_non", 2, NON1);
    run("s4_noff", 2, NOF1);
    run("s4_non2", 2, NON1);
    run("s4_noff2", 1, NOF1);
    bus.night = 1'b0;
    run("s4_noff2", 1, NOF1);
    run("s4_ar_exit", 1, AR1);
    run("s4_g1", 5, G1);
    run("s4_y1", 2, Y1);
    run("s4_ar0", 1, AR0);

    // asynchronous reset mid-yellow also clears a pending request
    bus.ped_req = 2'b10;
    run("s5_g0", 1, G0);
    bus.ped_req = 2'b00;
    run("s5_g0", 4, G0);
    run("s5_y0", 1, Y0);
    #2;
    rst = 1'b1;
    #1;
    check("s5_async_rst", G0);
    step();
    check("s5_rst_held", G0);
    rst = 1'b0;
    run("s5_g0b", 5, G0);
    run("s5_y0b", 2, Y0);
    run("s5_ar1", 1, AR1);
    run("s5_g1nowalk", 5, G1);
    run("s5_y1", 2, Y1);
    run("s5_ar0", 1, AR0);

    // request on the very edge that enters dir1 green
    run("s6_g0", 5, G0);
    run("s6_y0", 2, Y0);
    bus.ped_req = 2'b10;
    run("s6_ar1", 1, AR1);
    bus.ped_req = 2'b00;
    run("s6_g1walk", 8, G1W);
    run("s6_y1", 2, Y1);
    run("s6_ar0", 1, AR0);
    run("s6_g0b", 5, G0);
    run("s6_y0b", 2, Y0);
    run("s6_ar1b", 1, AR1);
    run("s6_g1nowalk", 5, G1);
    run("s6_y1b", 1, Y1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Parametrised N-direction traffic-light controller that runs directions round-robin through green, yellow and all-red clearance phases. Phase timing is counted in `tick` pulses from a shared prescaler. Per-direction pedestrian requests extend the green and light a walk signal, and a night mode switches to all-yellow flashing. It replaces the fixed two-direction, fixed-timing light sequencer in the DE0_CV design.

## Interface
- `N_DIR`, 2: number of directions, 2..8.
- `CNT_W`, 8: phase timer width.
- `GREEN_T`, 5: green duration in ticks.
- `YELLOW_T`, 2: yellow duration in ticks.
- `ALLRED_T`, 1: all-red clearance in ticks.
- `PED_EXT`, 3: extra green ticks when walk is granted.
- `BLINK_T`, 2: night half-period in ticks.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high; single clock domain.
- `tick`  in  1  timing enable; timers advance only on cycles with `tick`=1.
- `night`  in  1  night-mode request, level.
- `ped_req`  in  N_DIR  pedestrian request per direction; a one-cycle pulse is sufficient.
- `r`, `y`, `g`  out  N_DIR each  lamp drives; bit d is direction d.
- `walk`  out  N_DIR  pedestrian walk lamp.
- `dir`  out  $clog2(N_DIR)  currently served direction.

## Operation
- States: GREEN, YELLOW, ALLRED, NIGHT_ON, NIGHT_OFF. Timer `t` counts ticks spent in the current state.
- State end: a state ends on a cycle with `tick`=1 and `t` == duration-1. On that cycle `t` clears to 0; otherwise `t` increments on each tick.
- GREEN duration is GREEN_T, or GREEN_T+PED_EXT when walk was granted for this green.
- Transitions: GREEN→YELLOW. YELLOW→ALLRED, with `dir` advanced modulo N_DIR on the same edge. ALLRED→NIGHT_ON if `night`=1, else GREEN.
- Night mode: NIGHT_ON↔NIGHT_OFF toggle every BLINK_T ticks. At the end of either night state with `night`=0, go to ALLRED; `dir` is unchanged.
- Night mode is entered only at the end of ALLRED. A `night` rise during GREEN or YELLOW lets the cycle complete first.
- Outputs are Moore, decoded from registered state only:
  - GREEN: `g`[dir]=1, `r`=1 on all other bits.
  - YELLOW: `y`[dir]=1, `r`=1 on all other bits.
  - ALLRED: `r`=all ones.
  - NIGHT_ON: `y`=all ones, `r`=`g`=0.
  - NIGHT_OFF: all lamps 0.
- `walk`[dir]=1 only in GREEN when the walk grant is set; 0 in every other state.
- Pedestrian latch: `ped_pend`[d] sets on `ped_req`[d]=1. Requests are latched on every cycle regardless of `tick`.
- On the edge entering GREEN for direction d: the walk grant loads `ped_pend`[d], and `ped_pend`[d] clears. If a `ped_req`[d] arrives on that same edge, it is served by this green and does not stay pending.
- Requests are held through night mode.
- Reset values: state GREEN, `dir`=0, `t`=0, `ped_pend`=0, grant 0. Outputs: `g`=…01, `r`=…10, `y`=0, `walk`=0. Reset applies asynchronously at any point, including mid-phase.
- Elaboration asserts: every duration ≥1, and GREEN_T+PED_EXT < 2**CNT_W.

## Timing
- With `tick` held at 1, one direction occupies GREEN_T+YELLOW_T+ALLRED_T cycles, or PED_EXT more when walk is granted.
- An output changes on the clock edge after the terminal tick cycle.
- A `ped_req` pulse becomes visible in `ped_pend` one edge later.
- The first edge after reset deasserts counts as tick count 1 of GREEN, if `tick`=1.

## Structure
- `traffic_pkg`: `state_t` enum and lamp-pattern helper constants.
- Sub-module `phase_timer`: CNT_W counter with tick enable, clear, and terminal-match compare against a runtime duration input; outputs `done`.
- The FSM, pedestrian latch and output decode stay in `traffic_ctrl`.

## Test plan
All scenarios use N_DIR=2, GREEN_T=5, YELLOW_T=2, ALLRED_T=1, PED_EXT=3, BLINK_T=2.
- Reset, `tick`=1 continuously → `g`=01 `r`=10 for 5 cycles, then `y`=01 `r`=10 for 2, then `r`=11 for 1, then `g`=10 `dir`=1; full round period is 16 cycles.
- `ped_req`[1] pulse during dir0 green → `walk`=10 for all 8 green cycles of dir1; the following dir1 green lasts 5 cycles with `walk`=00.
- `tick` asserted every 4th cycle → every phase length ×4; lamps are stable between ticks.
- `night` raised mid-green → green, yellow and all-red complete; then `y`=11 for 2 ticks and `y`=00 for 2 ticks, repeating. `night` dropped → current blink half ends, then `r`=11 for 1 tick, then green on the next direction.
- `rst` asserted mid-yellow with no clock edge → outputs return to reset values immediately; `ped_pend` cleared.
- `ped_req`[1] on the same edge that enters dir1 green → `walk`=10 now, and no walk on the next dir1 green.
